bcd_to_bin: RTL and testbench

//  Sequential 2-digit BCD -> binary converter using reverse double dabble
//  (shift right, subtract 3). Inverse of the binary->BCD display path.

---
 rtl/bcd_to_bin.sv | 110 +++++++++++
 tb/tb_bcd_to_bin.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// Two-digit BCD to binary converter, reverse double dabble, one bit per clock.
// Start/done handshake; fixed BIN_W-cycle latency; start ignored while busy.
module bcd_to_bin #(
  parameter int BIN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       tens_i,
  input  logic [3:0]       ones_i,
  output logic [BIN_W-1:0] bin_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       bcd_q, bcd_d;
  logic [BIN_W-1:0] res_q, res_d;
  logic             inv_q, inv_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // One iteration: shift {bcd,res} right, then pull each BCD nibble back by 3 if >= 8
  logic [7:0]       bcd_sh;
  logic [7:0]       bcd_adj;
  logic [BIN_W-1:0] res_sh;

  assign bcd_sh = {1'b0, bcd_q[7:1]};
  assign res_sh = {bcd_q[0], res_q[BIN_W-1:1]};
  assign bcd_adj[7:4] = (bcd_sh[7:4] >= 4'd8) ? (bcd_sh[7:4] - 4'd3) : bcd_sh[7:4];
  assign bcd_adj[3:0] = (bcd_sh[3:0] >= 4'd8) ? (bcd_sh[3:0] - 4'd3) : bcd_sh[3:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    res_d   = res_q;
    inv_d   = inv_q;
    bin_d   = bin_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          bcd_d   = {tens_i, ones_i};
          res_d   = '0;
          inv_d   = (tens_i > 4'd9) | (ones_i > 4'd9);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bcd_d = bcd_adj;
        res_d = res_sh;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          bin_d   = inv_q ? '0 : res_sh;
          err_d   = inv_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      res_q   <= '0;
      inv_q   <= 1'b0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      res_q   <= res_d;
      inv_q   <= inv_d;
      bin_q   <= bin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bin_o  = bin_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed and random checks of bcd_to_bin against a decimal-arithmetic model.
module tb_bcd_to_bin;
  localparam int BIN_W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic [BIN_W-1:0] bin;
  logic             busy;
  logic             done;
  logic             err;

  int checks = 0;
  int errors = 0;

  bcd_to_bin #(.BIN_W(BIN_W)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start),
    .tens_i (tens),
    .ones_i (ones),
    .bin_o  (bin),
    .busy_o (busy),
    .done_o (done),
    .err_o  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain decimal value, zero for any out-of-range digit
  function automatic int model_bin(input int t, input int o);
    if (t > 9 || o > 9) return 0;
    return t * 10 + o;
  endfunction

  function automatic int model_err(input int t, input int o);
    return (t > 9 || o > 9) ? 1 : 0;
  endfunction

  task automatic check(input int obs, input int exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and let the accepting edge pass
  task automatic start_conv(input int t, input int o, input string tag);
    start = 1'b1;
    tens  = 4'(t);
    ones  = 4'(o);
    tick();
    start = 1'b0;
    check(int'(busy), 1, {tag, "_busy_rise"});
    check(int'(done), 0, {tag, "_done_low_at_start"});
  endtask

  // Wait for done, expecting it exactly lat edges from now; stays in the done cycle
  task automatic wait_done(input int lat, input int exp_bin, input int exp_err,
                           input string tag);
    int cyc = 0;
    while (!done && cyc < 40) begin
      check(int'(busy), 1, {tag, "_busy_hold"});
      tick();
      cyc++;
    end
    check(cyc, lat, {tag, "_latency"});
    check(int'(done), 1, {tag, "_done"});
    check(int'(busy), 0, {tag, "_busy_fall"});
    check(int'(bin), exp_bin, {tag, "_bin"});
    check(int'(err), exp_err, {tag, "_err"});
  endtask

  initial begin
    int t, o, gap;
    rst   = 1'b1;
    start = 1'b0;
    tens  = 4'd0;
    ones  = 4'd0;
    tick();
    tick();
    check(int'(bin), 0, "rst_bin");
    check(int'(busy), 0, "rst_busy");
    check(int'(done), 0, "rst_done");
    check(int'(err), 0, "rst_err");
    rst = 1'b0;
    tick();

    start_conv(0, 0, "t1");
    wait_done(BIN_W, 0, 0, "t1");
    tick();

    start_conv(9, 9, "t2");
    wait_done(BIN_W, 'h63, 0, "t2");
    tick();
    check(int'(done), 0, "t2_done_one_cycle");
    check(int'(bin), 'h63, "t2_bin_hold");

    start_conv(4, 2, "t3");
    wait_done(BIN_W, 'h2A, 0, "t3");
    tick();

    // Back-to-back: second request presented in the done cycle
    start_conv(1, 5, "t4a");
    wait_done(BIN_W, 'h0F, 0, "t4a");
    start_conv(3, 7, "t4b");
    wait_done(BIN_W, 'h25, 0, "t4b");
    tick();

    start_conv(4'hA, 3, "t5a");
    wait_done(BIN_W, 0, 1, "t5a");
    tick();
    check(int'(err), 1, "t5_err_hold");
    start_conv(2, 0, "t5b");
    wait_done(BIN_W, 'h14, 0, "t5b");
    tick();

    // Start while busy must be ignored
    start_conv(9, 9, "t6a");
    tick();
    tick();
    start = 1'b1;
    tens  = 4'd1;
    ones  = 4'd1;
    tick();
    start = 1'b0;
    wait_done(BIN_W - 3, 'h63, 0, "t6a");
    tick();

    // Reset mid-conversion aborts without a done pulse
    start_conv(5, 0, "t6b");
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check(int'(busy), 0, "t6b_rst_busy");
    check(int'(done), 0, "t6b_rst_done");
    check(int'(bin), 0, "t6b_rst_bin");
    check(int'(err), 0, "t6b_rst_err");
    for (int i = 0; i < BIN_W + 2; i++) begin
      tick();
      check(int'(done), 0, "t6b_no_done");
    end

    // Reset and start together: start is not captured
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check(int'(busy), 0, "rst_start_busy");
    tick();
    check(int'(busy), 0, "rst_start_busy2");

    start_conv(5, 0, "t6c");
    wait_done(BIN_W, 'h32, 0, "t6c");
    tick();

    for (int n = 0; n < 60; n++) begin
      t   = $urandom_range(0, 15);
      o   = $urandom_range(0, 15);
      gap = $urandom_range(0, 2);
      start_conv(t, o, "rnd");
      wait_done(BIN_W, model_bin(t, o), model_err(t, o), "rnd");
      for (int g = 0; g < gap; g++) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
